// File: rtl/ks_add_sequencer.sv
// Sequences a W-bit add/subtract through a shared external 16-bit adder,
// one slice per cycle from LSB to MSB, with valid/ready handshakes on both sides.
module ks_add_sequencer #(
   parameter int unsigned NSLICE = 4,
   localparam int unsigned W = 16 * NSLICE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_sub,
   input  logic         in_cin,
   output logic [15:0]  add_a,
   output logic [15:0]  add_b,
   output logic         add_cin,
   input  logic [15:0]  add_sum,
   input  logic         add_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_ovf,
   output logic         busy
);

   localparam int unsigned IDX_W = $clog2(NSLICE);
   localparam int unsigned OFF_W = IDX_W + 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, b_q, work_q, work_d;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic [OFF_W-1:0]   off;
   logic               last;

   // Bit offset of the current slice (idx * 16).
   assign off = {idx_q, 4'b0000};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, handshake outputs and adder slice muxing.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      work_d    = work_q;
      last      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            add_a            = a_q[off +: 16];
            add_b            = b_q[off +: 16];
            add_cin          = carry_q;
            work_d[off +: 16] = add_sum;
            last             = (idx_q == IDX_W'(NSLICE - 1));
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, slice accumulation and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_sub ? ~in_b : in_b;
                  carry_q <= in_sub | in_cin;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= add_cout;
               idx_q   <= idx_q + IDX_W'(1);
               if (last) begin
                  out_sum  <= work_d;
                  out_cout <= add_cout;
                  out_ovf  <= (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ks_add_sequencer.md
KS_ADD_SEQUENCER -- requirements
Module: ks_add_sequencer

Interface
REQ-001 Parameter NSLICE, default 4: number of 16-bit slices per operation; legal values 2..8; operand width W = 16*NSLICE.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 in_a  input  W  operand A.
REQ-007 in_b  input  W  operand B.
REQ-008 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 in_cin  input  1  carry-in, used only when in_sub=0.
REQ-010 add_a  output  16  A slice to the shared 16-bit Kogge-Stone adder.
REQ-011 add_b  output  16  B slice to the adder, already inverted when subtracting.
REQ-012 add_cin  output  1  slice carry-in to the adder.
REQ-013 add_sum  input  16  adder sum, combinational from add_a/add_b/add_cin.
REQ-014 add_cout  input  1  adder carry-out, combinational.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_sum  output  W  result.
REQ-018 out_cout  output  1  final carry-out; for subtraction, 1 = no borrow.
REQ-019 out_ovf  output  1  signed two's-complement overflow.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-022 IDLE SHALL drive in_ready=1; on in_valid=1 it SHALL capture in_a, the effective B (~in_b if in_sub else in_b) and the initial carry (1 if in_sub else in_cin), clear slice index idx to 0 and go to RUN.
REQ-023 in_ready SHALL be 0 in RUN and DONE; the block SHALL ignore and not capture in_* in those states.
REQ-024 In RUN, add_a/add_b SHALL carry captured slice idx (bits 16*idx+15:16*idx), and add_cin SHALL carry the carry register.
REQ-025 Each RUN edge SHALL write add_sum into result slice idx, load add_cout into the carry register and increment idx.
REQ-026 On the RUN edge with idx = NSLICE-1, the FSM SHALL go to DONE, latch out_cout = add_cout and latch out_ovf = (A[W-1] == Beff[W-1]) && (add_sum[15] != A[W-1]).
REQ-027 Latency: out_valid SHALL rise exactly NSLICE cycles after the acceptance edge.
REQ-028 DONE SHALL hold out_valid=1 with out_sum/out_cout/out_ovf stable until out_ready=1, then return to IDLE on that edge.
REQ-029 Minimum request-to-request spacing is NSLICE+2 cycles; the block SHALL NOT accept a request in the cycle it leaves DONE.
REQ-030 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-031 out_sum, out_cout and out_ovf SHALL keep the last result through IDLE until the next DONE overwrites them.
REQ-032 If in_valid and out_ready change in the same cycle, each SHALL be evaluated only in its own state; there is no bypass path.
REQ-033 Arithmetic SHALL be modulo 2^W; carry SHALL chain strictly from slice 0 (LSB) upward.

Reset
REQ-034 Assertion of rst_n=0 SHALL immediately force the state to IDLE, idx=0 and carry=0, and drive in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0 and out_ovf=0.
REQ-035 A reset during RUN or DONE SHALL abort the operation with no output and no retained partial result.
REQ-036 After deassertion, the first accept SHALL be possible on the first rising edge with in_valid=1.

Verification
REQ-037 NSLICE=4: A=0x0000_0000_0000_FFFF, B=1, sub=0, cin=0 -> out_sum=0x0000_0000_0001_0000, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-038 A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> sum=0, cout=1, ovf=0 (carry ripples through all 4 slices).
REQ-039 A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1; A=5, B=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-040 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_sum stay stable, in_ready=0 and the pulsed in_valid is ignored; release -> IDLE the next edge, then accept.
REQ-041 Assert rst_n=0 mid-RUN (idx=2) -> out_valid=0 and in_ready=1 immediately, outputs 0, and a new request completes correctly.
REQ-042 Back-to-back random 1000 operations with random in_valid/out_ready stalls -> every result matches the reference model (A±B, cout, ovf), and none are dropped or duplicated.
